// File: rtl/hand_score_bcd.sv
// rtl/hand_score_bcd.sv - per-hand blackjack scoring with BCD digit outputs
//
// Purpose:
//   Accepts dealt cards tagged with a hand (dealer, P1, P2) and keeps a
//   saturating hard total and an ace flag for each hand. After each accepted
//   card the selected hand's best ("max") and alternate ("min") totals are
//   converted to tens/ones digits. The conversion is iterative: 4 cycles for
//   max, then 4 for min. Both digit pairs are then written to the outputs
//   together in a single cycle.
//
// Optional build macro:
//   HAND_SCORE_DEALER_HINT_EN - adds the registered output dealer_must_hit,
//   which is 1 while the dealer's best total is below DEALER_STAND.
//
// Ports:
//   iCLK_50MHZ      in   1  system clock
//   iRST            in   1  asynchronous active-high reset
//   clear_hands     in   1  zero all hands; overrides everything else
//   card_valid      in   1  card present this cycle
//   card_ready      out  1  block can accept a card (IDLE and no clear)
//   card_rank       in   4  1=Ace, 2..10 pip, 11..13 face; 0/14/15 dropped
//   player_sel      in   2  0=dealer, 1=P1, 2=P2; 3 dropped
//   dmax_tens/ones  out  4  dealer best total digits
//   p1max_*/p2max_* out  4  player best total digits
//   p1min_*/p2min_* out  4  player alternate total digits (0/0 if none)
//   busy            out  1  score conversion/update in progress
//   dealer_must_hit out  1  (macro only) dealer best total < DEALER_STAND

module hand_score_bcd #(
    parameter int WIN_LIMIT    = 21,
    parameter int SAT_LIMIT    = 31,
    parameter int DEALER_STAND = 17
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST,
    input  logic       clear_hands,
    input  logic       card_valid,
    output logic       card_ready,
    input  logic [3:0] card_rank,
    input  logic [1:0] player_sel,
    output logic [3:0] dmax_tens,
    output logic [3:0] dmax_ones,
    output logic [3:0] p1max_tens,
    output logic [3:0] p1max_ones,
    output logic [3:0] p1min_tens,
    output logic [3:0] p1min_ones,
    output logic [3:0] p2max_tens,
    output logic [3:0] p2max_ones,
    output logic [3:0] p2min_tens,
    output logic [3:0] p2min_ones,
    output logic       busy
`ifdef HAND_SCORE_DEALER_HINT_EN
    ,
    output logic       dealer_must_hit
`endif
);

    // Totals are held in 5 bits; larger limits cannot be represented.
    if (SAT_LIMIT > 31 || WIN_LIMIT + 10 > 31 || DEALER_STAND > 31) begin : g_bad_params
        $error("hand_score_bcd: limit parameters must fit in 5 bits");
    end

    localparam logic [5:0] LP_SAT6 = 6'(SAT_LIMIT);
    localparam logic [4:0] LP_SAT5 = 5'(SAT_LIMIT);
    localparam logic [5:0] LP_WIN6 = 6'(WIN_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_CONV_MAX,
        S_CONV_MIN,
        S_UPDATE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cnt;

    // Per-hand running state
    logic [4:0] r_hard_d;
    logic [4:0] r_hard_p1;
    logic [4:0] r_hard_p2;
    logic [2:0] r_ace;

    // Captured card
    logic [1:0] r_sel;
    logic [3:0] r_val;
    logic       r_is_ace;

    // Conversion datapath
    logic [4:0] r_conv;
    logic [1:0] r_tens;
    logic [4:0] r_min_bin;
    logic [1:0] r_max_tens;
    logic [3:0] r_max_ones;

    // Output registers
    logic [3:0] r_dmax_tens;
    logic [3:0] r_dmax_ones;
    logic [3:0] r_p1max_tens;
    logic [3:0] r_p1max_ones;
    logic [3:0] r_p1min_tens;
    logic [3:0] r_p1min_ones;
    logic [3:0] r_p2max_tens;
    logic [3:0] r_p2max_ones;
    logic [3:0] r_p2min_tens;
    logic [3:0] r_p2min_ones;

`ifdef HAND_SCORE_DEALER_HINT_EN
    localparam logic [4:0] LP_STAND5 = 5'(DEALER_STAND);
    logic [4:0] r_max_bin;
    logic       r_must_hit;
`endif

    logic       w_rank_ok;
    logic       w_sel_ok;
    logic       w_accept;
    logic [4:0] w_cur_hard;
    logic       w_cur_ace;
    logic [5:0] w_sum6;
    logic [4:0] w_new_hard;
    logic       w_new_ace;
    logic [5:0] w_soft6;
    logic       w_soft_ok;
    logic [4:0] w_max;
    logic [4:0] w_min;
    logic       w_ge10;
    logic [4:0] w_step_conv;
    logic [1:0] w_step_tens;

    assign w_rank_ok = (card_rank >= 4'd1) && (card_rank <= 4'd13);
    assign w_sel_ok  = (player_sel != 2'd3);
    assign w_accept  = card_valid && card_ready && w_rank_ok && w_sel_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK_50MHZ or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // busy covers the conversion and update cycles; the ADD cycle is
    // already covered by card_ready being low.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        card_ready = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                card_ready = !clear_hands;
                if (w_accept) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                w_next = S_CONV_MAX;
            end
            S_CONV_MAX: begin
                busy = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_next = S_CONV_MIN;
                end
            end
            S_CONV_MIN: begin
                busy = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (clear_hands) begin
            w_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Hand arithmetic for the captured card
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_hard = r_hard_d;
        w_cur_ace  = r_ace[0];
        case (r_sel)
            2'd1: begin
                w_cur_hard = r_hard_p1;
                w_cur_ace  = r_ace[1];
            end
            2'd2: begin
                w_cur_hard = r_hard_p2;
                w_cur_ace  = r_ace[2];
            end
            default: begin
                w_cur_hard = r_hard_d;
                w_cur_ace  = r_ace[0];
            end
        endcase
    end

    assign w_sum6     = {1'b0, w_cur_hard} + {2'b00, r_val};
    assign w_new_hard = (w_sum6 > LP_SAT6) ? LP_SAT5 : w_sum6[4:0];
    assign w_new_ace  = w_cur_ace | r_is_ace;

    // An ace may count as 11 only while that keeps the hand within the limit.
    assign w_soft6    = {1'b0, w_new_hard} + 6'd10;
    assign w_soft_ok  = w_new_ace && (w_soft6 <= LP_WIN6);
    assign w_max      = w_soft_ok ? w_soft6[4:0] : w_new_hard;
    assign w_min      = w_soft_ok ? w_new_hard   : 5'd0;

    // One compare/subtract step; four steps cover every value up to 31.
    assign w_ge10      = (r_conv >= 5'd10);
    assign w_step_conv = w_ge10 ? (r_conv - 5'd10) : r_conv;
    assign w_step_tens = w_ge10 ? (r_tens + 2'd1)  : r_tens;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK_50MHZ or posedge iRST) begin
        if (iRST) begin
            r_cnt        <= 2'd0;
            r_hard_d     <= 5'd0;
            r_hard_p1    <= 5'd0;
            r_hard_p2    <= 5'd0;
            r_ace        <= 3'b000;
            r_sel        <= 2'd0;
            r_val        <= 4'd0;
            r_is_ace     <= 1'b0;
            r_conv       <= 5'd0;
            r_tens       <= 2'd0;
            r_min_bin    <= 5'd0;
            r_max_tens   <= 2'd0;
            r_max_ones   <= 4'd0;
            r_dmax_tens  <= 4'd0;
            r_dmax_ones  <= 4'd0;
            r_p1max_tens <= 4'd0;
            r_p1max_ones <= 4'd0;
            r_p1min_tens <= 4'd0;
            r_p1min_ones <= 4'd0;
            r_p2max_tens <= 4'd0;
            r_p2max_ones <= 4'd0;
            r_p2min_tens <= 4'd0;
            r_p2min_ones <= 4'd0;
`ifdef HAND_SCORE_DEALER_HINT_EN
            r_max_bin    <= 5'd0;
            r_must_hit   <= 1'b1;
`endif
        end else if (clear_hands) begin
            r_cnt        <= 2'd0;
            r_hard_d     <= 5'd0;
            r_hard_p1    <= 5'd0;
            r_hard_p2    <= 5'd0;
            r_ace        <= 3'b000;
            r_dmax_tens  <= 4'd0;
            r_dmax_ones  <= 4'd0;
            r_p1max_tens <= 4'd0;
            r_p1max_ones <= 4'd0;
            r_p1min_tens <= 4'd0;
            r_p1min_ones <= 4'd0;
            r_p2max_tens <= 4'd0;
            r_p2max_ones <= 4'd0;
            r_p2min_tens <= 4'd0;
            r_p2min_ones <= 4'd0;
`ifdef HAND_SCORE_DEALER_HINT_EN
            r_must_hit   <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel    <= player_sel;
                        r_val    <= (card_rank > 4'd10) ? 4'd10 : card_rank;
                        r_is_ace <= (card_rank == 4'd1);
                    end
                end
                S_ADD: begin
                    case (r_sel)
                        2'd1:    r_hard_p1 <= w_new_hard;
                        2'd2:    r_hard_p2 <= w_new_hard;
                        default: r_hard_d  <= w_new_hard;
                    endcase
                    r_ace[r_sel] <= w_new_ace;
                    r_conv       <= w_max;
                    r_tens       <= 2'd0;
                    r_min_bin    <= w_min;
                    r_cnt        <= 2'd0;
`ifdef HAND_SCORE_DEALER_HINT_EN
                    r_max_bin    <= w_max;
`endif
                end
                S_CONV_MAX: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        // Final step: bank the max digits and start on min.
                        r_max_tens <= w_step_tens;
                        r_max_ones <= w_step_conv[3:0];
                        r_conv     <= r_min_bin;
                        r_tens     <= 2'd0;
                    end else begin
                        r_conv <= w_step_conv;
                        r_tens <= w_step_tens;
                    end
                end
                S_CONV_MIN: begin
                    r_cnt  <= r_cnt + 2'd1;
                    r_conv <= w_step_conv;
                    r_tens <= w_step_tens;
                end
                S_UPDATE: begin
                    // The dealer's alternate total is not displayed.
                    case (r_sel)
                        2'd1: begin
                            r_p1max_tens <= {2'b00, r_max_tens};
                            r_p1max_ones <= r_max_ones;
                            r_p1min_tens <= {2'b00, r_tens};
                            r_p1min_ones <= r_conv[3:0];
                        end
                        2'd2: begin
                            r_p2max_tens <= {2'b00, r_max_tens};
                            r_p2max_ones <= r_max_ones;
                            r_p2min_tens <= {2'b00, r_tens};
                            r_p2min_ones <= r_conv[3:0];
                        end
                        default: begin
                            r_dmax_tens <= {2'b00, r_max_tens};
                            r_dmax_ones <= r_max_ones;
`ifdef HAND_SCORE_DEALER_HINT_EN
                            r_must_hit  <= (r_max_bin < LP_STAND5);
`endif
                        end
                    endcase
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign dmax_tens  = r_dmax_tens;
    assign dmax_ones  = r_dmax_ones;
    assign p1max_tens = r_p1max_tens;
    assign p1max_ones = r_p1max_ones;
    assign p1min_tens = r_p1min_tens;
    assign p1min_ones = r_p1min_ones;
    assign p2max_tens = r_p2max_tens;
    assign p2max_ones = r_p2max_ones;
    assign p2min_tens = r_p2min_tens;
    assign p2min_ones = r_p2min_ones;
`ifdef HAND_SCORE_DEALER_HINT_EN
    assign dealer_must_hit = r_must_hit;
`endif

endmodule

// File: tb/tb_hand_score_bcd.sv
// tb/tb_hand_score_bcd.sv - self-checking bench for hand_score_bcd
module tb_hand_score_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_hands;
    logic       card_valid;
    logic       card_ready;
    logic [3:0] card_rank;
    logic [1:0] player_sel;
    logic [3:0] dmax_tens, dmax_ones;
    logic [3:0] p1max_tens, p1max_ones, p1min_tens, p1min_ones;
    logic [3:0] p2max_tens, p2max_ones, p2min_tens, p2min_ones;
    logic       busy;
`ifdef HAND_SCORE_DEALER_HINT_EN
    logic       dealer_must_hit;
`endif

    hand_score_bcd dut (
        .iCLK_50MHZ (clk),
        .iRST       (rst),
        .clear_hands(clear_hands),
        .card_valid (card_valid),
        .card_ready (card_ready),
        .card_rank  (card_rank),
        .player_sel (player_sel),
        .dmax_tens  (dmax_tens),
        .dmax_ones  (dmax_ones),
        .p1max_tens (p1max_tens),
        .p1max_ones (p1max_ones),
        .p1min_tens (p1min_tens),
        .p1min_ones (p1min_ones),
        .p2max_tens (p2max_tens),
        .p2max_ones (p2max_ones),
        .p2min_tens (p2min_tens),
        .p2min_ones (p2min_ones),
        .busy       (busy)
`ifdef HAND_SCORE_DEALER_HINT_EN
        ,
        .dealer_must_hit(dealer_must_hit)
`endif
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: hand totals by the card-game rules
    int m_hard[3];
    bit m_ace[3];
    int m_max[3];
    int m_min[3];
    bit m_hit;

    task automatic model_clear();
        for (int h = 0; h < 3; h++) begin
            m_hard[h] = 0;
            m_ace[h]  = 0;
            m_max[h]  = 0;
            m_min[h]  = 0;
        end
        m_hit = 1;
    endtask

    task automatic model_apply(input int rank, input int sel);
        int v;
        if (rank < 1 || rank > 13 || sel > 2) return;
        v = (rank > 10) ? 10 : rank;
        m_hard[sel] = (m_hard[sel] + v > 31) ? 31 : m_hard[sel] + v;
        if (rank == 1) m_ace[sel] = 1;
        if (m_ace[sel] && m_hard[sel] + 10 <= 21) begin
            m_max[sel] = m_hard[sel] + 10;
            m_min[sel] = m_hard[sel];
        end else begin
            m_max[sel] = m_hard[sel];
            m_min[sel] = 0;
        end
        if (sel == 0) m_hit = (m_max[0] < 17);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".dmax_t"},  32'(dmax_tens),  32'(m_max[0] / 10));
        chk({tag, ".dmax_o"},  32'(dmax_ones),  32'(m_max[0] % 10));
        chk({tag, ".p1max_t"}, 32'(p1max_tens), 32'(m_max[1] / 10));
        chk({tag, ".p1max_o"}, 32'(p1max_ones), 32'(m_max[1] % 10));
        chk({tag, ".p1min_t"}, 32'(p1min_tens), 32'(m_min[1] / 10));
        chk({tag, ".p1min_o"}, 32'(p1min_ones), 32'(m_min[1] % 10));
        chk({tag, ".p2max_t"}, 32'(p2max_tens), 32'(m_max[2] / 10));
        chk({tag, ".p2max_o"}, 32'(p2max_ones), 32'(m_max[2] % 10));
        chk({tag, ".p2min_t"}, 32'(p2min_tens), 32'(m_min[2] / 10));
        chk({tag, ".p2min_o"}, 32'(p2min_ones), 32'(m_min[2] % 10));
        chk({tag, ".busy"},    32'(busy),       32'd0);
`ifdef HAND_SCORE_DEALER_HINT_EN
        chk({tag, ".hit"},     32'(dealer_must_hit), 32'(m_hit));
`endif
    endtask

    // Present a card for one cycle, then wait until the update has landed.
    task automatic send_card(input int rank, input int sel);
        @(negedge clk);
        card_valid = 1'b1;
        card_rank  = 4'(rank);
        player_sel = 2'(sel);
        @(negedge clk);
        card_valid = 1'b0;
        repeat (10) @(negedge clk);
        model_apply(rank, sel);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_hands = 1'b1;
        @(negedge clk);
        clear_hands = 1'b0;
        model_clear();
    endtask

    initial begin
        int busy_cycles;
        int r, s;

        rst         = 1'b1;
        clear_hands = 1'b0;
        card_valid  = 1'b0;
        card_rank   = 4'd0;
        player_sel  = 2'd0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_outputs("reset");
        chk("reset.ready", 32'(card_ready), 32'd1);

        // Ace to P1: latency and busy width
        @(negedge clk);
        card_valid = 1'b1;
        card_rank  = 4'd1;
        player_sel = 2'd1;
        @(negedge clk);
        card_valid = 1'b0;
        chk("ace.ready_low", 32'(card_ready), 32'd0);
        busy_cycles = 0;
        for (int k = 2; k <= 11; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (k == 10) chk("ace.not_yet", 32'(p1max_ones), 32'd0);
        end
        model_apply(1, 1);
        chk("ace.busy_cycles", 32'(busy_cycles), 32'd9);
        check_outputs("ace");

        // P1: A, K, 5 -> 21/11 then 16/0
        send_card(13, 1);
        check_outputs("p1_k");
        send_card(5, 1);
        check_outputs("p1_5");

        // Dealer K, Q, J, 10 -> saturates at 31
        send_card(13, 0);
        check_outputs("d_k");
        send_card(12, 0);
        check_outputs("d_q");
        send_card(11, 0);
        send_card(10, 0);
        check_outputs("d_sat");

        // Illegal cards while idle
        for (int t = 0; t < 3; t++) begin
            int ir, is;
            ir = (t == 0) ? 14 : ((t == 1) ? 5 : 0);
            is = (t == 1) ? 3 : 2;
            @(negedge clk);
            card_valid = 1'b1;
            card_rank  = 4'(ir);
            player_sel = 2'(is);
            @(negedge clk);
            card_valid = 1'b0;
            @(negedge clk);
            chk("illegal.busy", 32'(busy), 32'd0);
            chk("illegal.ready", 32'(card_ready), 32'd1);
            repeat (9) @(negedge clk);
            check_outputs("illegal");
        end

        // card_valid held through busy with a different card
        @(negedge clk);
        card_valid = 1'b1;
        card_rank  = 4'd7;
        player_sel = 2'd2;
        @(negedge clk);
        card_rank  = 4'd9;
        repeat (10) @(negedge clk);
        card_valid = 1'b0;
        model_apply(7, 2);
        check_outputs("held");
        repeat (12) @(negedge clk);
        check_outputs("held_after");

        // clear_hands during CONV_MAX together with a new card
        @(negedge clk);
        card_valid = 1'b1;
        card_rank  = 4'd3;
        player_sel = 2'd2;
        @(negedge clk);
        card_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("clr.busy_before", 32'(busy), 32'd1);
        clear_hands = 1'b1;
        card_valid  = 1'b1;
        card_rank   = 4'd5;
        player_sel  = 2'd2;
        #1;
        chk("clr.ready_low", 32'(card_ready), 32'd0);
        @(negedge clk);
        model_clear();
        check_outputs("clr");
        clear_hands = 1'b0;
        card_valid  = 1'b0;
        #1;
        chk("clr.ready", 32'(card_ready), 32'd1);
        send_card(4, 2);
        check_outputs("clr_next");

        // Asynchronous reset mid-conversion
        send_card(9, 1);
        @(negedge clk);
        card_valid = 1'b1;
        card_rank  = 4'd8;
        player_sel = 2'd1;
        @(negedge clk);
        card_valid = 1'b0;
        repeat (3) @(negedge clk);
        #5 rst = 1'b1;
        #1;
        model_clear();
        check_outputs("rst_mid");
        chk("rst_mid.ready", 32'(card_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        send_card(5, 1);
        check_outputs("rst_next");

        // Randomized cards against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulse_clear();
                check_outputs("rnd_clr");
            end else begin
                r = int'($urandom_range(0, 15));
                s = int'($urandom_range(0, 3));
                send_card(r, s);
                check_outputs("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
